// File: rtl/adxl345_pkg.sv
// ADXL345 register map, SPI command-frame layout and responder state encoding.
// Shared between the responder model and the adxl345 driver.
package adxl345_pkg;

    localparam logic [5:0] REG_DEVID       = 6'h00;
    localparam logic [5:0] REG_POWER_CTL   = 6'h2D;
    localparam logic [5:0] REG_INT_ENABLE  = 6'h2E;
    localparam logic [5:0] REG_DATA_FORMAT = 6'h31;
    localparam logic [5:0] REG_DATAX0      = 6'h32;
    localparam logic [5:0] REG_DATAX1      = 6'h33;
    localparam logic [5:0] REG_DATAY0      = 6'h34;
    localparam logic [5:0] REG_DATAY1      = 6'h35;
    localparam logic [5:0] REG_DATAZ0      = 6'h36;
    localparam logic [5:0] REG_DATAZ1      = 6'h37;
    localparam logic [5:0] REG_FIFO_CTL    = 6'h38;

    localparam logic REG_READ  = 1'b1;
    localparam logic REG_WRITE = 1'b0;

    // Field positions within the command byte (frame bits 15:8)
    localparam int CMD_RW_BIT   = 7;
    localparam int CMD_MB_BIT   = 6;
    localparam int CMD_ADDR_MSB = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_HOLD
    } resp_state_t;

    function automatic logic is_read_only(input logic [5:0] a);
        return (a == REG_DEVID) || ((a >= REG_DATAX0) && (a <= REG_DATAZ1));
    endfunction

endpackage

// File: rtl/adxl345_spi_responder_if.sv
// SPI pin bundle between a mode-3 master and the ADXL345 responder.
interface adxl345_spi_responder_if;
    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (output sclk, output cs_n, output mosi, input miso, input miso_oe);
    modport slave  (input sclk, input cs_n, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_pin_sync.sv
// Synchronizes SPI pins into the clk domain and produces single-cycle edge pulses.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic cs_n_s,
    output logic mosi_s,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_fall,
    output logic cs_rise
);
    logic [SYNC_STAGES-1:0] sclk_p0, cs_p0, mosi_p0, fill_p0;
    logic sclk_p1, cs_p1, armed;
    logic sclk_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_p0 <= '1;
            cs_p0   <= '1;
            mosi_p0 <= '0;
            fill_p0 <= '0;
            sclk_p1 <= 1'b1;
            cs_p1   <= 1'b1;
            armed   <= 1'b0;
        end else begin
            sclk_p0 <= {sclk_p0[SYNC_STAGES-2:0], sclk};
            cs_p0   <= {cs_p0[SYNC_STAGES-2:0], cs_n};
            mosi_p0 <= {mosi_p0[SYNC_STAGES-2:0], mosi};
            fill_p0 <= {fill_p0[SYNC_STAGES-2:0], 1'b1};
            sclk_p1 <= sclk_s;
            cs_p1   <= cs_n_s;
            // A frame already in progress at reset release must not look like a fresh select
            if (fill_p0[SYNC_STAGES-1] && cs_n_s)
                armed <= 1'b1;
        end
    end

    assign sclk_s    = sclk_p0[SYNC_STAGES-1];
    assign cs_n_s    = cs_p0[SYNC_STAGES-1];
    assign mosi_s    = mosi_p0[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_p1;
    assign sclk_fall = ~sclk_s & sclk_p1;
    assign cs_fall   = armed & ~cs_n_s & cs_p1;
    assign cs_rise   = cs_n_s & ~cs_p1;

endmodule

// File: rtl/adxl345_spi_responder.sv
// ADXL345-style SPI mode-3 register-file responder: 16-bit command frames with
// multi-byte auto-increment, read-only ID/data registers and coherent sample loading.
module adxl345_spi_responder
    import adxl345_pkg::*;
#(
    parameter logic [7:0] DEVID       = 8'hE5,
    parameter int         NUM_REGS    = 64,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    adxl345_spi_responder_if.slave spi,
    input  logic                 sample_valid,
    input  logic signed [15:0]   sample_x,
    input  logic signed [15:0]   sample_y,
    input  logic signed [15:0]   sample_z,
    output logic                 wr_valid,
    output logic [5:0]           wr_addr,
    output logic [7:0]           wr_data,
    output logic                 frame_error
);
    logic cs_n_s, mosi_s, sclk_rise, sclk_fall, cs_fall, cs_rise;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .sclk      (spi.sclk),
        .cs_n      (spi.cs_n),
        .mosi      (spi.mosi),
        .cs_n_s    (cs_n_s),
        .mosi_s    (mosi_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise)
    );

    resp_state_t state, state_nxt;
    logic [2:0] bit_cnt;
    logic [6:0] sin;
    logic [7:0] sout;
    logic       rw, mb, miso_r;
    logic [5:0] addr;
    logic [7:0] regs [NUM_REGS];

    logic               pend_vld;
    logic signed [15:0] pend_x, pend_y, pend_z;

    logic               byte_done, commit, load_now, pend_apply;
    logic [7:0]         rx_byte, rd_cmd, rd_next;
    logic [5:0]         cmd_addr, next_addr;
    logic signed [15:0] sel_x, sel_y, sel_z;

    always_comb begin
        byte_done  = sclk_rise && (bit_cnt == 3'd7);
        rx_byte    = {sin, mosi_s};
        cmd_addr   = rx_byte[CMD_ADDR_MSB:0];
        next_addr  = addr + 6'd1;
        rd_cmd     = (cmd_addr == REG_DEVID) ? DEVID : regs[cmd_addr];
        rd_next    = (next_addr == REG_DEVID) ? DEVID : regs[next_addr];
        commit     = (state == ST_DATA) && !cs_rise && byte_done && (rw == REG_WRITE);
        load_now   = sample_valid && cs_n_s && !cs_rise;
        pend_apply = pend_vld && cs_n_s && !cs_rise;
        sel_x      = load_now ? sample_x : pend_x;
        sel_y      = load_now ? sample_y : pend_y;
        sel_z      = load_now ? sample_z : pend_z;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cs_rise) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (cs_fall) state_nxt = ST_CMD;
                ST_CMD:  if (byte_done) state_nxt = ST_DATA;
                ST_DATA: if (byte_done && !mb) state_nxt = ST_HOLD;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt     <= 3'd0;
            sin         <= 7'd0;
            sout        <= 8'd0;
            rw          <= 1'b0;
            mb          <= 1'b0;
            addr        <= 6'd0;
            miso_r      <= 1'b0;
            wr_valid    <= 1'b0;
            wr_addr     <= 6'd0;
            wr_data     <= 8'd0;
            frame_error <= 1'b0;
        end else begin
            wr_valid    <= 1'b0;
            frame_error <= 1'b0;
            if (cs_rise) begin
                if ((state != ST_IDLE) && (bit_cnt != 3'd0))
                    frame_error <= 1'b1;
                bit_cnt <= 3'd0;
                miso_r  <= 1'b0;
            end else if (state == ST_IDLE) begin
                if (cs_fall) begin
                    bit_cnt <= 3'd0;
                    miso_r  <= 1'b0;
                end
            end else begin
                if (sclk_rise) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    sin     <= {sin[5:0], mosi_s};
                end
                if ((state != ST_CMD) && sclk_fall) begin
                    miso_r <= sout[7];
                    sout   <= {sout[6:0], 1'b0};
                end
                if ((state == ST_CMD) && byte_done) begin
                    rw   <= rx_byte[CMD_RW_BIT];
                    mb   <= rx_byte[CMD_MB_BIT];
                    addr <= cmd_addr;
                    sout <= (rx_byte[CMD_RW_BIT] == REG_READ) ? rd_cmd : 8'd0;
                end
                if ((state == ST_DATA) && byte_done) begin
                    if (rw == REG_WRITE) begin
                        wr_valid <= 1'b1;
                        wr_addr  <= addr;
                        wr_data  <= rx_byte;
                    end
                    if (mb) begin
                        addr <= next_addr;
                        if (rw == REG_READ) sout <= rd_next;
                    end
                end
            end
        end
    end

    // Samples arriving while selected wait in a one-deep buffer so a burst read sees one coherent set
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'd0;
            pend_vld <= 1'b0;
            pend_x   <= '0;
            pend_y   <= '0;
            pend_z   <= '0;
        end else begin
            if (commit && !is_read_only(addr))
                regs[addr] <= rx_byte;
            if (load_now || pend_apply) begin
                regs[REG_DATAX0] <= sel_x[7:0];
                regs[REG_DATAX1] <= sel_x[15:8];
                regs[REG_DATAY0] <= sel_y[7:0];
                regs[REG_DATAY1] <= sel_y[15:8];
                regs[REG_DATAZ0] <= sel_z[7:0];
                regs[REG_DATAZ1] <= sel_z[15:8];
                pend_vld         <= 1'b0;
            end
            if (sample_valid && !load_now) begin
                pend_vld <= 1'b1;
                pend_x   <= sample_x;
                pend_y   <= sample_y;
                pend_z   <= sample_z;
            end
        end
    end

    assign spi.miso    = miso_r;
    assign spi.miso_oe = ~cs_n_s;

endmodule
